// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, one parity bit, one stop bit, selectable baud rate,
// single-entry output holding register, sticky error flags and an armed byte counter.
module uart_rx #(
  parameter int FREQ         = 50000000,
  parameter int CONFIG_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      rx,
  output logic [7:0]                dout,
  output logic                      dout_valid,
  input  logic                      dout_ready,
  input  logic [CONFIG_WIDTH-1:0]   rx_conf,
  output logic [2:0]                err,
  input  logic                      clear_err,
  input  logic [CONFIG_WIDTH/2-1:0] enable,
  input  logic [CONFIG_WIDTH/2-1:0] clear,
  output logic                      done
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  localparam logic [31:0] LIM0 = 32'(FREQ / 1200 - 1);
  localparam logic [31:0] LIM1 = 32'(FREQ / 2400 - 1);
  localparam logic [31:0] LIM2 = 32'(FREQ / 4800 - 1);
  localparam logic [31:0] LIM3 = 32'(FREQ / 9600 - 1);
  localparam logic [31:0] LIM4 = 32'(FREQ / 19200 - 1);
  localparam logic [31:0] LIM5 = 32'(FREQ / 38400 - 1);
  localparam logic [31:0] LIM6 = 32'(FREQ / 57600 - 1);
  localparam logic [31:0] LIM7 = 32'(FREQ / 115200 - 1);

  state_t      state, state_next;
  logic [1:0]  sync;
  logic        rx_s, rx_prev;
  logic [31:0] cnt, cnt_next, limit, limit_next;
  logic        odd, odd_next;
  logic [7:0]  shift, shift_next;
  logic [2:0]  bit_idx, bit_idx_next;
  logic        deliver, set_parity, set_frame, overrun, handshake;
  logic [5:0]  byte_cnt;
  logic        any_en, any_clr;
  logic        unused_cfg;

  function automatic logic [31:0] bit_limit(input logic [15:0] sel);
    case (sel)
      16'd0:   return LIM0;
      16'd1:   return LIM1;
      16'd2:   return LIM2;
      16'd3:   return LIM3;
      16'd4:   return LIM4;
      16'd5:   return LIM5;
      16'd6:   return LIM6;
      default: return LIM7;
    endcase
  endfunction

  assign rx_s       = sync[1];
  assign handshake  = dout_valid & dout_ready;
  assign overrun    = deliver & dout_valid & ~dout_ready;
  assign any_en     = |enable[5:0];
  assign any_clr    = |clear[5:0];
  assign unused_cfg = ^{rx_conf[15:1], enable[CONFIG_WIDTH/2-1:6], clear[CONFIG_WIDTH/2-1:6]};

  always_ff @(posedge clock) begin
    if (reset) begin
      sync    <= '1;
      rx_prev <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      limit   <= '0;
      odd     <= 1'b0;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      sync    <= {sync[0], rx};
      rx_prev <= rx_s;
      state   <= state_next;
      cnt     <= cnt_next;
      limit   <= limit_next;
      odd     <= odd_next;
      shift   <= shift_next;
      bit_idx <= bit_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt + 32'd1;
    limit_next   = limit;
    odd_next     = odd;
    shift_next   = shift;
    bit_idx_next = bit_idx;
    deliver      = 1'b0;
    set_parity   = 1'b0;
    set_frame    = 1'b0;
    case (state)
      IDLE: begin
        cnt_next = '0;
        // Baud and parity mode are captured here so later rx_conf writes cannot disturb this frame.
        if (rx_prev && !rx_s) begin
          state_next = START;
          limit_next = bit_limit(rx_conf[31:16]);
          odd_next   = rx_conf[0];
        end
      end
      START: begin
        if (cnt == (limit >> 1)) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == limit) begin
          cnt_next     = '0;
          shift_next   = {rx_s, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_next = PARITY;
        end
      end
      PARITY: begin
        if (cnt == limit) begin
          cnt_next   = '0;
          set_parity = rx_s != ((^shift) ^ odd);
          state_next = STOP;
        end
      end
      STOP: begin
        if (cnt == limit) begin
          cnt_next = '0;
          if (rx_s) begin
            deliver    = 1'b1;
            state_next = IDLE;
          end else begin
            set_frame  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= '0;
      byte_cnt   <= '0;
    end else begin
      if (deliver && !overrun) begin
        dout       <= shift;
        dout_valid <= 1'b1;
      end else if (handshake) begin
        dout_valid <= 1'b0;
      end
      if (clear_err) err <= '0;
      else           err <= err | {overrun, set_frame, set_parity};
      if (any_en && any_clr)                byte_cnt <= '0;
      else if (handshake && any_en && !done) byte_cnt <= byte_cnt + 6'd1;
    end
  end

  always_comb begin
    done = 1'b0;
    for (int unsigned k = 0; k < 6; k++)
      done = done | (enable[k] & (byte_cnt == 6'(1 << k)));
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 50 MHz / 115200 baud: table-driven frames plus
// hand-written corner sequences, with a scoreboard queue checked at each handshake.
module tb_uart_rx;
  localparam int BIT = 434;

  logic        clock = 1'b0;
  logic        reset, rx, dout_ready, clear_err, dout_valid, done;
  logic [7:0]  dout;
  logic [31:0] rx_conf;
  logic [2:0]  err;
  logic [15:0] enable, clear;

  int tests = 0, fails = 0, hs_count = 0, hs0;
  logic [7:0] q[$];
  logic [7:0] exp_byte;

  typedef struct {
    logic [7:0] data;
    logic       odd;
    logic       par;
    logic       scramble;
    logic [2:0] exp_err;
  } vec_t;
  vec_t vecs[4];

  uart_rx #(.FREQ(50000000), .CONFIG_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .rx(rx), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .rx_conf(rx_conf), .err(err), .clear_err(clear_err),
    .enable(enable), .clear(clear), .done(done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset && dout_valid && dout_ready) begin
      hs_count++;
      if (q.size() == 0) begin
        check("unexpected_delivery", {24'd0, dout}, 32'hFFFF_FFFF);
      end else begin
        exp_byte = q.pop_front();
        check("dout", {24'd0, dout}, {24'd0, exp_byte});
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic pulse_clear_err();
    clear_err = 1'b1;
    wait_cycles(1);
    clear_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input logic scramble);
    logic [31:0] saved;
    saved = rx_conf;
    rx = 1'b0;
    wait_cycles(BIT);
    if (scramble) rx_conf = {16'd0, 15'd0, ~saved[0]};
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_cycles(BIT);
    end
    rx = p;
    wait_cycles(BIT);
    rx = stop;
    wait_cycles(BIT);
    rx_conf = saved;
  endtask

  initial begin
    vecs[0] = '{8'h5A, 1'b0, 1'b0, 1'b0, 3'b000};
    vecs[1] = '{8'h01, 1'b1, 1'b1, 1'b0, 3'b001};
    vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'b000};
    vecs[3] = '{8'h80, 1'b0, 1'b0, 1'b0, 3'b001};

    reset = 1'b1; rx = 1'b1; dout_ready = 1'b1; clear_err = 1'b0;
    rx_conf = {16'd7, 16'd0}; enable = '0; clear = '0;
    #1;
    wait_cycles(4);
    reset = 1'b0;
    wait_cycles(4);
    @(negedge clock);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_valid", {31'd0, dout_valid}, 32'd0);
    check("reset_err", {29'd0, err}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    wait_cycles(1);

    for (int i = 0; i < 4; i++) begin
      rx_conf = {16'd7, 15'd0, vecs[i].odd};
      q.push_back(vecs[i].data);
      hs0 = hs_count;
      send_frame(vecs[i].data, vecs[i].par, 1'b1, vecs[i].scramble);
      wait_cycles(20);
      @(negedge clock);
      check("vec_err", {29'd0, err}, {29'd0, vecs[i].exp_err});
      check("vec_pulses", hs_count - hs0, 32'd1);
      wait_cycles(1);
      pulse_clear_err();
      @(negedge clock);
      check("vec_err_cleared", {29'd0, err}, 32'd0);
      wait_cycles(1);
    end

    // short low glitch is a false start
    rx_conf = {16'd7, 16'd0};
    hs0 = hs_count;
    rx = 1'b0;
    wait_cycles(100);
    rx = 1'b1;
    wait_cycles(600);
    @(negedge clock);
    check("glitch_pulses", hs_count - hs0, 32'd0);
    check("glitch_err", {29'd0, err}, 32'd0);
    wait_cycles(1);

    // framing error, line held low, then recovery
    hs0 = hs_count;
    send_frame(8'h00, 1'b0, 1'b0, 1'b0);
    wait_cycles(22 * BIT);
    rx = 1'b1;
    wait_cycles(BIT);
    @(negedge clock);
    check("frame_err", {29'd0, err}, 32'd2);
    check("frame_pulses", hs_count - hs0, 32'd0);
    wait_cycles(1);
    pulse_clear_err();
    q.push_back(8'hC3);
    hs0 = hs_count;
    send_frame(8'hC3, 1'b0, 1'b1, 1'b0);
    wait_cycles(20);
    @(negedge clock);
    check("recover_err", {29'd0, err}, 32'd0);
    check("recover_pulses", hs_count - hs0, 32'd1);
    wait_cycles(1);

    // overrun: second byte dropped while first is held
    dout_ready = 1'b0;
    hs0 = hs_count;
    q.push_back(8'h11);
    send_frame(8'h11, 1'b0, 1'b1, 1'b0);
    send_frame(8'h22, 1'b0, 1'b1, 1'b0);
    wait_cycles(20);
    @(negedge clock);
    check("ovr_dout", {24'd0, dout}, 32'h11);
    check("ovr_valid", {31'd0, dout_valid}, 32'd1);
    check("ovr_err", {29'd0, err}, 32'd4);
    check("ovr_pulses", hs_count - hs0, 32'd0);
    wait_cycles(1);
    dout_ready = 1'b1;
    wait_cycles(5);
    @(negedge clock);
    check("ovr_drain_valid", {31'd0, dout_valid}, 32'd0);
    check("ovr_drain_pulses", hs_count - hs0, 32'd1);
    check("ovr_queue", q.size(), 32'd0);
    wait_cycles(1);
    pulse_clear_err();

    // reset in the middle of a frame
    hs0 = hs_count;
    rx = 1'b0;
    wait_cycles(BIT);
    rx = 1'b1;
    wait_cycles(BIT / 2);
    reset = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(12 * BIT);
    @(negedge clock);
    check("midrst_dout", {24'd0, dout}, 32'd0);
    check("midrst_valid", {31'd0, dout_valid}, 32'd0);
    check("midrst_err", {29'd0, err}, 32'd0);
    check("midrst_pulses", hs_count - hs0, 32'd0);
    wait_cycles(1);

    // byte counter armed for four bytes
    enable = 16'h0004;
    wait_cycles(1);
    @(negedge clock);
    check("cnt_done_init", {31'd0, done}, 32'd0);
    wait_cycles(1);
    for (int b = 0; b < 5; b++) begin
      logic [7:0] d;
      d = 8'h10 + 8'(b * 7);
      q.push_back(d);
      send_frame(d, ^d, 1'b1, 1'b0);
      wait_cycles(20);
      @(negedge clock);
      check("cnt_done", {31'd0, done}, (b >= 3) ? 32'd1 : 32'd0);
      wait_cycles(1);
    end
    clear = 16'h0001;
    wait_cycles(1);
    clear = '0;
    @(negedge clock);
    check("cnt_cleared_done", {31'd0, done}, 32'd0);
    check("final_err", {29'd0, err}, 32'd0);
    check("final_queue", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
